// File: rtl/in_deser_align.sv
// Serial-to-parallel deserializer, MSB first, with manual bitslip
// and automatic word alignment against a fixed training pattern.
module in_deser_align #(
  parameter int unsigned             WIDTH     = 8,
  parameter logic [WIDTH-1:0]        ALIGN_PAT = WIDTH'(8'h3C)
) (
  input  logic                       SCLK,
  input  logic                       CDN,
  input  logic                       CD,
  input  logic                       D,
  input  logic                       BITSLIP,
  input  logic                       ALIGN_REQ,
  output logic [WIDTH-1:0]           Q,
  output logic                       QVALID,
  output logic                       LOCKED,
  output logic                       ALIGN_ERR,
  output logic [$clog2(WIDTH)-1:0]   SLIP_CNT
);

  localparam int CW = $clog2(WIDTH);
  localparam int TW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    SETTLE,
    LOCK
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    slip_cnt_q, slip_cnt_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qv_q, qv_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] word;
  logic             ext_slip;
  logic             int_slip;
  logic             slip;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slip_cnt_d = slip_cnt_q;
    tries_d    = tries_q;
    q_d        = q_q;
    qv_d       = 1'b0;
    err_d      = err_q;
    int_slip   = 1'b0;
    word       = {sr_q, D};
    sr_d       = word[WIDTH-2:0];
    ext_slip   = BITSLIP && !ALIGN_REQ &&
                 (state_q == IDLE || state_q == LOCK);

    unique case (state_q)
      IDLE: begin
        if (ALIGN_REQ) begin
          state_d = SEARCH;
          err_d   = 1'b0;
          tries_d = '0;
        end
      end
      SEARCH: begin
        if (ALIGN_REQ) begin
          tries_d = '0;
        end else if (qv_q) begin
          if (q_q == ALIGN_PAT) begin
            state_d = LOCK;
          end else if (tries_q == TW'(WIDTH)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            int_slip = 1'b1;
            tries_d  = tries_q + 1'b1;
            state_d  = SETTLE;
          end
        end
      end
      SETTLE: begin
        // word right after a slip is dropped unchecked
        if (ALIGN_REQ) begin
          tries_d = '0;
          state_d = SEARCH;
        end else if (qv_q) begin
          state_d = SEARCH;
        end
      end
      LOCK: begin
        if (ALIGN_REQ) begin
          state_d = SEARCH;
          err_d   = 1'b0;
          tries_d = '0;
        end else if (BITSLIP) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    slip = ext_slip || int_slip;

    if (slip) begin
      slip_cnt_d = (slip_cnt_q == CW'(WIDTH - 1)) ?
                   '0 : slip_cnt_q + 1'b1;
    end else if (cnt_q == CW'(WIDTH - 1)) begin
      q_d   = word;
      qv_d  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (CD) begin
      state_d    = IDLE;
      sr_d       = '0;
      cnt_d      = '0;
      slip_cnt_d = '0;
      tries_d    = '0;
      q_d        = '0;
      qv_d       = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge SCLK or negedge CDN) begin
    if (!CDN) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      slip_cnt_q <= '0;
      tries_q    <= '0;
      q_q        <= '0;
      qv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      slip_cnt_q <= slip_cnt_d;
      tries_q    <= tries_d;
      q_q        <= q_d;
      qv_q       <= qv_d;
      err_q      <= err_d;
    end
  end

  assign Q         = q_q;
  assign QVALID    = qv_q;
  assign LOCKED    = (state_q == LOCK);
  assign ALIGN_ERR = err_q;
  assign SLIP_CNT  = slip_cnt_q;

endmodule

// File: tb/tb_in_deser_align.sv
// Directed bench for in_deser_align: expected words queued at
// stimulus time, popped when QVALID strobes.
module tb_in_deser_align;

  logic       SCLK = 1'b0;
  logic       CDN = 1'b0;
  logic       CD = 1'b0;
  logic       D = 1'b0;
  logic       BITSLIP = 1'b0;
  logic       ALIGN_REQ = 1'b0;
  logic [7:0] Q;
  logic       QVALID;
  logic       LOCKED;
  logic       ALIGN_ERR;
  logic [2:0] SLIP_CNT;

  int n_vec = 0;
  int n_err = 0;
  bit sb_en = 1'b1;
  logic [7:0] sbq[$];
  int k;

  in_deser_align #(.WIDTH(8), .ALIGN_PAT(8'h3C)) dut (
    .SCLK(SCLK), .CDN(CDN), .CD(CD), .D(D),
    .BITSLIP(BITSLIP), .ALIGN_REQ(ALIGN_REQ),
    .Q(Q), .QVALID(QVALID), .LOCKED(LOCKED),
    .ALIGN_ERR(ALIGN_ERR), .SLIP_CNT(SLIP_CNT)
  );

  always #5 SCLK = ~SCLK;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge SCLK) begin
    if (sb_en && QVALID === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_qvalid", {24'd0, Q}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = sbq.pop_front();
        chk("word", {24'd0, Q}, {24'd0, e});
      end
    end
  end

  task automatic step(logic d, logic bs, logic ar);
    D = d;
    BITSLIP = bs;
    ALIGN_REQ = ar;
    @(posedge SCLK);
    #1;
    BITSLIP = 1'b0;
    ALIGN_REQ = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, int slip_at);
    for (int i = 0; i < 8; i++) step(b[7-i], (i == slip_at), 1'b0);
  endtask

  task automatic clr();
    CD = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    CD = 1'b0;
  endtask

  // E1 is 3C rotated left by 3: five one-bit-later slips realign it
  task automatic align_lock();
    logic [7:0] p;
    p = 8'hE1;
    clr();
    sb_en = 1'b0;
    step(p[7], 1'b0, 1'b1);
    k = 1;
    while (k < 400 && LOCKED !== 1'b1) begin
      step(p[7-(k%8)], 1'b0, 1'b0);
      k++;
    end
    chk("lock_reached", {31'd0, LOCKED}, 32'd1);
    chk("lock_slips", {29'd0, SLIP_CNT}, 32'd5);
    chk("lock_err", {31'd0, ALIGN_ERR}, 32'd0);
    sb_en = 1'b1;
    repeat (3) sbq.push_back(8'h3C);
    repeat (24) begin
      step(p[7-(k%8)], 1'b0, 1'b0);
      k++;
    end
    chk("lock_held", {31'd0, LOCKED}, 32'd1);
  endtask

  initial begin
    logic [7:0] x, y, z, w, a, b;
    repeat (2) @(posedge SCLK);
    #1;
    chk("rst_q", {24'd0, Q}, 32'd0);
    chk("rst_qvalid", {31'd0, QVALID}, 32'd0);
    chk("rst_locked", {31'd0, LOCKED}, 32'd0);
    chk("rst_err", {31'd0, ALIGN_ERR}, 32'd0);
    chk("rst_slip", {29'd0, SLIP_CNT}, 32'd0);
    #3 CDN = 1'b1;
    #1;

    // plain words
    sbq.push_back(8'hA5);
    sbq.push_back(8'h5A);
    x = 8'hA5;
    for (int i = 0; i < 7; i++) step(x[7-i], 1'b0, 1'b0);
    chk("a5_early", {31'd0, QVALID}, 32'd0);
    step(x[0], 1'b0, 1'b0);
    chk("a5_strobe", {31'd0, QVALID}, 32'd1);
    send_byte(8'h5A, -1);
    chk("5a_strobe", {31'd0, QVALID}, 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("strobe_one_cycle", {31'd0, QVALID}, 32'd0);

    // BITSLIP at bit 3 of a word
    clr();
    x = 8'h96; y = 8'h0F; z = 8'hF0; w = 8'h33;
    sbq.push_back({x[6:0], y[7]});
    sbq.push_back({y[6:0], z[7]});
    sbq.push_back({z[6:0], w[7]});
    send_byte(x, 3);
    chk("slip3_no_emit", {31'd0, QVALID}, 32'd0);
    chk("slip3_cnt", {29'd0, SLIP_CNT}, 32'd1);
    send_byte(y, -1);
    send_byte(z, -1);
    send_byte(w, -1);

    // BITSLIP on the last bit of a word
    clr();
    chk("cd_slip_clr", {29'd0, SLIP_CNT}, 32'd0);
    a = 8'hC6; b = 8'h81;
    sbq.push_back({a[6:0], b[7]});
    send_byte(a, 7);
    chk("slip7_no_emit", {31'd0, QVALID}, 32'd0);
    chk("slip7_cnt", {29'd0, SLIP_CNT}, 32'd1);
    step(b[7], 1'b0, 1'b0);
    chk("slip7_deferred", {31'd0, QVALID}, 32'd1);
    for (int i = 1; i < 8; i++) step(b[7-i], 1'b0, 1'b0);

    // automatic alignment
    align_lock();

    // exhausted search on an all-zero stream
    clr();
    sb_en = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    k = 1;
    while (k < 400 && ALIGN_ERR !== 1'b1) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
    end
    chk("err_set", {31'd0, ALIGN_ERR}, 32'd1);
    chk("err_unlocked", {31'd0, LOCKED}, 32'd0);
    chk("err_slip_wrap", {29'd0, SLIP_CNT}, 32'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("idle_bitslip", {29'd0, SLIP_CNT}, 32'd1);
    step(1'b0, 1'b1, 1'b1);
    chk("req_clears_err", {31'd0, ALIGN_ERR}, 32'd0);
    chk("req_beats_slip", {29'd0, SLIP_CNT}, 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("search_ign_slip", {29'd0, SLIP_CNT}, 32'd1);
    clr();
    sb_en = 1'b1;

    // async reset mid-word while locked
    align_lock();
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0);
    end
    #2 CDN = 1'b0;
    #1;
    chk("cdn_q", {24'd0, Q}, 32'd0);
    chk("cdn_qvalid", {31'd0, QVALID}, 32'd0);
    chk("cdn_locked", {31'd0, LOCKED}, 32'd0);
    chk("cdn_slip", {29'd0, SLIP_CNT}, 32'd0);
    CDN = 1'b1;
    @(posedge SCLK);
    #1;

    // synchronous clear mid-word
    clr();
    step(1'b0, 1'b1, 1'b0);
    chk("pre_cd_slip", {29'd0, SLIP_CNT}, 32'd1);
    sbq.push_back(8'h77);
    send_byte(8'h77, -1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    CD = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    CD = 1'b0;
    chk("cd_q", {24'd0, Q}, 32'd0);
    chk("cd_qvalid", {31'd0, QVALID}, 32'd0);
    chk("cd_slip", {29'd0, SLIP_CNT}, 32'd0);
    chk("cd_err", {31'd0, ALIGN_ERR}, 32'd0);
    x = 8'hC3;
    sbq.push_back(x);
    for (int i = 0; i < 7; i++) step(x[7-i], 1'b0, 1'b0);
    chk("cd_word_early", {31'd0, QVALID}, 32'd0);
    step(x[0], 1'b0, 1'b0);
    chk("cd_word_strobe", {31'd0, QVALID}, 32'd1);
    @(negedge SCLK);
    #1;
    chk("sb_drained", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
